// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 encodings,
// FSM state enum and request-decode helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int         F3_UNS = 2;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } lsu_state_e;

  // Byte-lane mask of an access of 2^size bytes, clipped to nb lanes.
  function automatic logic [7:0] size_mask(input logic [1:0] size, input int nb);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    if (nb < 8) m = m & ((8'd1 << nb) - 8'd1);
    return m;
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                      input int data_w);
    return ((funct3[1:0] == SZ_D) && (data_w == 32)) ||
           (funct3[F3_UNS] && we) ||
           (funct3 == F3_ILLEGAL);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension: takes right-justified merged load bytes and
// sign- or zero-extends them to DATA_W according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rdata
);

  // Push the access MSB to the top, then shift back arithmetically or logically.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] size,
                                               input logic uns);
    int sh;
    logic signed [DATA_W-1:0] top;
    logic signed [DATA_W-1:0] sext;
    sh   = ((8 << size) >= DATA_W) ? 0 : DATA_W - (8 << size);
    top  = d << sh;
    sext = top >>> sh;
    if (uns) return (d << sh) >> sh;
    return sext;
  endfunction

  assign rdata = extend(raw, funct3[1:0], funct3[F3_UNS]);

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit between MEM stage and a data-memory port.
// Define LSU_MISALIGN_SPLIT_EN to split beat-crossing accesses into two beats.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(NB);

  lsu_state_e state_q, state_d;

  logic              we_q;
  logic              fault_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_lo_q;
  logic [DATA_W-1:0] buf_hi_q;

  logic                accept;
  logic                illegal;
  logic                beat1;
  logic [OFF_W-1:0]    off;
  logic [NB-1:0]       mask;
  logic [2*NB-1:0]     be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [ADDR_W-1:0]   base_addr;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   ext_data;

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign illegal = is_illegal(req_we, req_funct3, DATA_W);
`else
  logic [OFF_W-1:0] req_amask;
  assign req_amask = OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1);
  assign illegal   = is_illegal(req_we, req_funct3, DATA_W) ||
                     ((req_addr[OFF_W-1:0] & req_amask) != '0);
`endif

  // Both beats come from one double-width shift: the low half is beat 0,
  // the high half is whatever spilled past the lane boundary (beat 1).
  assign off       = addr_q[OFF_W-1:0];
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mask      = NB'(size_mask(funct3_q[1:0], NB));
  assign be_wide   = {{NB{1'b0}}, mask} << off;
  assign wd_wide   = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [3:0] size_bytes;
  logic       split;
  assign size_bytes = 4'd1 << funct3_q[1:0];
  assign split      = (5'(off) + 5'(size_bytes)) > 5'(NB);
  assign beat1      = (state_q == REQ1);
`else
  assign beat1 = 1'b0;
`endif

  assign merged = DATA_W'({buf_hi_q, buf_lo_q} >> {off, 3'b000});

  lsu_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw    (merged),
    .funct3 (funct3_q),
    .rdata  (ext_data)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = illegal ? RESP : REQ0;
      REQ0:  if (mem_gnt) state_d = WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
      WAIT0: if (mem_rvalid) state_d = split ? REQ1 : RESP;
      REQ1:  if (mem_gnt) state_d = WAIT1;
      WAIT1: if (mem_rvalid) state_d = RESP;
`else
      WAIT0: if (mem_rvalid) state_d = RESP;
`endif
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_lo_q <= '0;
      buf_hi_q <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        fault_q  <= illegal;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        buf_hi_q <= '0;
      end
      if ((state_q == WAIT0) && mem_rvalid) buf_lo_q <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if ((state_q == WAIT1) && mem_rvalid) buf_hi_q <= mem_rdata;
`endif
    end
  end

  // Memory fields are forced to zero outside a request so idle/reset outputs read 0.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_req   = (state_q == REQ0) || beat1;
    mem_we    = mem_req && we_q;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) mem_addr = beat1 ? base_addr + BEAT_STRIDE : base_addr;
    if (mem_we) begin
      mem_be    = beat1 ? be_wide[2*NB-1:NB] : be_wide[NB-1:0];
      mem_wdata = beat1 ? wd_wide[2*DATA_W-1:DATA_W] : wd_wide[DATA_W-1:0];
    end
    rsp_valid = (state_q == RESP);
    rsp_fault = rsp_valid && fault_q;
    rsp_rdata = (rsp_valid && !fault_q && !we_q) ? ext_data : '0;
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit: directed table, hand-written corner
// sequences and randomized traffic against a byte-addressed memory model.
module tb_lsu_align_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  logic        req_valid, req_we, req_ready, rsp_valid, rsp_fault;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        auto_on, a_gnt, a_rvalid, m_gnt, m_rvalid;
  logic [31:0] a_rdata, m_rdata;
  assign mem_gnt    = auto_on ? a_gnt    : m_gnt;
  assign mem_rvalid = auto_on ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_on ? a_rdata  : m_rdata;

  lsu_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_fault;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr, d_mem_addr;
  logic [63:0] d_req_wdata, d_rsp_rdata, d_mem_wdata, d_mem_rdata;
  logic        d_mem_req, d_mem_we, d_mem_gnt, d_mem_rvalid;
  logic [7:0]  d_mem_be;

  lsu_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .n_rst(n_rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(1'b0),
    .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata), .rsp_fault(d_rsp_fault),
    .mem_req(d_mem_req), .mem_gnt(d_mem_gnt), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_be(d_mem_be), .mem_wdata(d_mem_wdata), .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Two byte memories: phys is what the DUT's beats touch, refm is the model's view.
  byte unsigned phys[int unsigned];
  byte unsigned refm[int unsigned];

  function automatic byte unsigned init_byte(input int unsigned a);
    return 8'((a * 37) + 11);
  endfunction
  function automatic byte unsigned rd_phys(input int unsigned a);
    return phys.exists(a) ? phys[a] : init_byte(a);
  endfunction
  function automatic byte unsigned rd_ref(input int unsigned a);
    return refm.exists(a) ? refm[a] : init_byte(a);
  endfunction

  function automatic bit model_legal(input bit we, input logic [2:0] f3, input int unsigned addr);
    int sz;
    sz = 1 << f3[1:0];
    if (f3[1:0] == 2'd3) return 1'b0;
    if (f3[2] && we) return 1'b0;
    if (!SPLIT_EN && (addr % sz) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned addr);
    longint unsigned v;
    int sz;
    sz = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < sz; i++) v = v | (longint'(rd_ref(addr + i)) << (8 * i));
    if (!f3[2] && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * sz)) - 1);
    return v[31:0];
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;
  beat_t beats[$];

  // Randomly-stalling memory: grants a pending request, answers 1-3 cycles later.
  initial begin
    int cnt;
    bit pend;
    logic [31:0] rd;
    a_gnt = 0; a_rvalid = 0; a_rdata = '0; pend = 0; cnt = 0; rd = '0;
    forever begin
      @(negedge clk);
      a_gnt = 0; a_rvalid = 0;
      if (pend) begin
        if (cnt == 0) begin a_rvalid = 1; a_rdata = rd; pend = 0; end
        else cnt--;
      end else if (auto_on && mem_req && ($urandom_range(2) != 0)) begin
        a_gnt = 1;
        beats.push_back('{mem_addr, mem_be, mem_wdata});
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) phys[mem_addr + i] = mem_wdata[8*i +: 8];
          rd[8*i +: 8] = rd_phys(mem_addr + i);
        end
        pend = 1;
        cnt = $urandom_range(2);
      end
    end
  end

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output bit got_fault, output logic [31:0] got_rdata,
                     output int nbeat, output bit timeout);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    beats.delete();
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    timeout   = !rsp_valid;
    got_fault = rsp_fault;
    got_rdata = rsp_rdata;
    nbeat     = beats.size();
  endtask

  task automatic txn64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rd,
                       output logic [63:0] got, output bit ok);
    int n;
    @(negedge clk);
    d_req_valid = 1; d_req_funct3 = f3; d_req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 0;
    n = 0;
    while (!d_mem_req && n < 10) begin @(negedge clk); n++; end
    d_mem_gnt = 1;
    @(negedge clk);
    d_mem_gnt = 0; d_mem_rvalid = 1; d_mem_rdata = rd;
    @(negedge clk);
    d_mem_rvalid = 0;
    ok  = d_rsp_valid;
    got = d_rsp_rdata;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          exp_fault;
    logic [31:0] exp_rdata;
    int          exp_beats;
    logic [31:0] exp_addr0;
    logic [3:0]  exp_be0;
    logic [31:0] exp_wd0;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gf, to, we, ok, el;
    logic [2:0]  f3;
    logic [31:0] gr, ad, wd, er;
    logic [63:0] g64;
    int nb, eb, sz;

    tbl[0]  = '{0, 3'd0, 32'h1003, 32'h0,      0, 32'hFFFF_FF80, 1, 32'h1000, 4'b0000, 32'h0};
    tbl[1]  = '{1, 3'd1, 32'h2002, 32'h0000_ABCD, 0, 32'h0,      1, 32'h2000, 4'b1100, 32'hABCD_0000};
    tbl[2]  = '{0, 3'd4, 32'h1003, 32'h0,      0, 32'h0000_0080, 1, 32'h1000, 4'b0000, 32'h0};
    tbl[3]  = '{0, 3'd1, 32'h1002, 32'h0,      0, 32'hFFFF_80FF, 1, 32'h1000, 4'b0000, 32'h0};
    tbl[4]  = '{0, 3'd5, 32'h1000, 32'h0,      0, 32'h0000_FF00, 1, 32'h1000, 4'b0000, 32'h0};
    tbl[5]  = '{0, 3'd2, 32'h1000, 32'h0,      0, 32'h80FF_FF00, 1, 32'h1000, 4'b0000, 32'h0};
    tbl[6]  = '{1, 3'd0, 32'h2001, 32'h0000_005A, 0, 32'h0,      1, 32'h2000, 4'b0010, 32'h0000_5A00};
    tbl[7]  = '{1, 3'd3, 32'h2000, 32'h1234_5678, 1, 32'h0,      0, 32'h0,    4'b0000, 32'h0};
    tbl[8]  = '{1, 3'd4, 32'h2000, 32'h1234_5678, 1, 32'h0,      0, 32'h0,    4'b0000, 32'h0};
    tbl[9]  = '{0, 3'd7, 32'h1000, 32'h0,      1, 32'h0,         0, 32'h0,    4'b0000, 32'h0};
    tbl[10] = '{0, 3'd2, 32'h2000, 32'h0,      0, 32'hABCD_5A0B, 1, 32'h2000, 4'b0000, 32'h0};

    phys[32'h1000] = 8'h00; phys[32'h1001] = 8'hFF;
    phys[32'h1002] = 8'hFF; phys[32'h1003] = 8'h80;

    n_rst = 0; auto_on = 1; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    req_valid = 0; req_we = 0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    d_req_valid = 0; d_req_funct3 = '0; d_req_addr = '0; d_req_wdata = '0;
    d_mem_gnt = 0; d_mem_rvalid = 0; d_mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst64_rsp_valid", d_rsp_valid, 0);
    n_rst = 1;

    // Aligned load latency with immediate grant and next-cycle rvalid.
    auto_on = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("lat_mem_req_t1", mem_req, 1);
    check("lat_mem_addr_t1", mem_addr, 32'h1000);
    check("lat_rsp_t1", rsp_valid, 0);
    m_gnt = 1;
    @(negedge clk);
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1357_2468;
    check("lat_mem_req_t2", mem_req, 0);
    check("lat_rsp_t2", rsp_valid, 0);
    @(negedge clk);
    m_rvalid = 0;
    check("lat_rsp_t3", rsp_valid, 1);
    check("lat_rdata_t3", rsp_rdata, 32'h1357_2468);
    @(negedge clk);
    check("lat_rsp_pulse", rsp_valid, 0);
    check("lat_ready", req_ready, 1);

    auto_on = 1;
    foreach (tbl[i]) begin
      txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, gf, gr, nb, to);
      check($sformatf("tbl%0d_timeout", i), to, 0);
      check($sformatf("tbl%0d_fault", i), gf, tbl[i].exp_fault);
      check($sformatf("tbl%0d_rdata", i), gr, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_beats", i), nb, tbl[i].exp_beats);
      if (tbl[i].exp_beats > 0 && beats.size() > 0) begin
        check($sformatf("tbl%0d_addr0", i), beats[0].addr, tbl[i].exp_addr0);
        check($sformatf("tbl%0d_be0", i), beats[0].be, tbl[i].exp_be0);
        if (tbl[i].we) check($sformatf("tbl%0d_wdata0", i), beats[0].wdata, tbl[i].exp_wd0);
      end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    txn(1, 3'd2, 32'h3003, 32'h1122_3344, gf, gr, nb, to);
    check("split_st_timeout", to, 0);
    check("split_st_fault", gf, 0);
    check("split_st_beats", nb, 2);
    if (beats.size() == 2) begin
      check("split_b0_addr", beats[0].addr, 32'h3000);
      check("split_b0_be", beats[0].be, 4'b1000);
      check("split_b0_wdata", beats[0].wdata, 32'h4400_0000);
      check("split_b1_addr", beats[1].addr, 32'h3004);
      check("split_b1_be", beats[1].be, 4'b0111);
      check("split_b1_wdata", beats[1].wdata, 32'h0011_2233);
    end
    txn(0, 3'd2, 32'h3003, 32'h0, gf, gr, nb, to);
    check("split_ld_beats", nb, 2);
    check("split_ld_rdata", gr, 32'h1122_3344);
`else
    auto_on = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h3003;
    check("mis_mem_req_accept", mem_req, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    check("mis_rsp_valid", rsp_valid, 1);
    check("mis_rsp_fault", rsp_fault, 1);
    check("mis_rsp_rdata", rsp_rdata, 0);
    check("mis_mem_req", mem_req, 0);
    @(negedge clk);
    check("mis_rsp_done", rsp_valid, 0);
    check("mis_mem_req_after", mem_req, 0);
    auto_on = 1;
`endif

    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(1));
      f3 = 3'($urandom_range(7));
      ad = 32'h100 + $urandom_range(63);
      wd = $urandom;
      el = model_legal(we, f3, ad);
      sz = 1 << f3[1:0];
      eb = !el ? 0 : (((ad % 4) + sz > 4) ? 2 : 1);
      er = (!we && el) ? model_load(f3, ad) : 32'h0;
      txn(we, f3, ad, wd, gf, gr, nb, to);
      check($sformatf("rnd%0d_timeout", k), to, 0);
      check($sformatf("rnd%0d_fault", k), gf, !el);
      check($sformatf("rnd%0d_rdata", k), gr, er);
      check($sformatf("rnd%0d_beats", k), nb, eb);
      if (we && el) for (int i = 0; i < sz; i++) refm[ad + i] = wd[8*i +: 8];
    end

    // Stalled grant, then reset while waiting for rvalid; the late rvalid is ignored.
    auto_on = 0;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h1004; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_req", c), mem_req, 1);
      check($sformatf("stall%0d_addr", c), mem_addr, 32'h1004);
      check($sformatf("stall%0d_be", c), mem_be, 4'hF);
      check($sformatf("stall%0d_wdata", c), mem_wdata, 32'hCAFE_F00D);
      @(negedge clk);
    end
    m_gnt = 1;
    @(negedge clk);
    m_gnt = 0;
    check("wait0_mem_req", mem_req, 0);
    #2 n_rst = 0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_be", mem_be, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_fault", rsp_fault, 0);
    check("arst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    n_rst = 1;
    m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("late%0d_rsp", c), rsp_valid, 0);
      check($sformatf("late%0d_ready", c), req_ready, 1);
      @(negedge clk);
    end

    txn64(3'd3, 32'h8, 64'hDEAD_BEEF_0123_4567, g64, ok);
    check("ld64_valid", ok, 1);
    check("ld64_rdata", g64, 64'hDEAD_BEEF_0123_4567);
    txn64(3'd6, 32'hC, 64'hDEAD_BEEF_0123_4567, g64, ok);
    check("lwu64_valid", ok, 1);
    check("lwu64_rdata", g64, 64'h0000_0000_DEAD_BEEF);
    txn64(3'd2, 32'hC, 64'hDEAD_BEEF_0123_4567, g64, ok);
    check("lw64_valid", ok, 1);
    check("lw64_rdata", g64, 64'hFFFF_FFFF_DEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
